// File: rtl/cmp_seq_pkg.sv
// Shared constants and sizing helpers for the chunked magnitude comparator.
// Feedback codes carry the decided/undecided result between chunk slices.
package cmp_seq_pkg;

  typedef logic [1:0] fb_t;
  typedef logic [1:0] state_t;

  localparam fb_t FB_EQ = 2'b00;
  localparam fb_t FB_LT = 2'b10;
  localparam fb_t FB_GT = 2'b01;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_COMPARE = 2'd1;
  localparam state_t ST_DONE    = 2'd2;

  function automatic int unsigned num_chunks(input int unsigned width,
                                             input int unsigned chunk);
    return width / chunk;
  endfunction

  // Counter must hold the value NCHUNK itself, hence the +1.
  function automatic int unsigned cnt_width(input int unsigned nchunk);
    return $clog2(nchunk + 1);
  endfunction

endpackage

// File: rtl/cmp_chunk_slice.sv
// One CHUNK-bit slice of the magnitude comparator; combinational.
// A decided feedback code passes through, an undecided one is resolved here.
module cmp_chunk_slice
  import cmp_seq_pkg::*;
#(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] chunk_a_i,
  input  logic [CHUNK-1:0] chunk_b_i,
  input  logic [1:0]       fb_i,
  output logic [1:0]       fb_o
);

  always_comb begin
    fb_o = fb_i;
    if (fb_i == FB_EQ) begin
      if (chunk_a_i < chunk_b_i) begin
        fb_o = FB_LT;
      end else if (chunk_a_i > chunk_b_i) begin
        fb_o = FB_GT;
      end
    end
  end

endmodule

// File: rtl/cmp_chunk_sequencer.sv
// Multi-cycle unsigned magnitude comparator: one CHUNK slice per cycle, MSB first,
// with valid/ready handshakes on request and result sides.
module cmp_chunk_sequencer
  import cmp_seq_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned CHUNK      = 8,
  parameter int unsigned EARLY_EXIT = 1,
  localparam int unsigned NCHUNK    = num_chunks(WIDTH, CHUNK),
  localparam int unsigned CNT_W     = cnt_width(NCHUNK)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             clear_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             less_o,
  output logic             equal_o,
  output logic             greater_o,
  output logic [CNT_W-1:0] chunks_used_o,
  output logic             busy_o
);

  if ((CHUNK == 0) || (WIDTH == 0) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
    $error("cmp_chunk_sequencer: WIDTH must be a non-zero multiple of CHUNK");
  end

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NCHUNK - 1);

  state_t           state_q, state_d;
  fb_t              fb_q, fb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;

  logic [CHUNK-1:0] chunk_a, chunk_b;
  fb_t              fb_slice;
  logic             decided;

  // Chunk select as an explicit mux so idx_q never enters an index multiply.
  always_comb begin
    chunk_a = '0;
    chunk_b = '0;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      if (idx_q == CNT_W'(i)) begin
        chunk_a = a_q[i*CHUNK +: CHUNK];
        chunk_b = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  cmp_chunk_slice #(
    .CHUNK(CHUNK)
  ) u_slice (
    .chunk_a_i(chunk_a),
    .chunk_b_i(chunk_b),
    .fb_i     (fb_q),
    .fb_o     (fb_slice)
  );

  assign decided = (EARLY_EXIT != 0) && (fb_slice != FB_EQ);

  always_comb begin
    state_d = state_q;
    fb_d    = fb_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    if (clear_i) begin
      state_d = ST_IDLE;
      fb_d    = FB_EQ;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_d = ST_COMPARE;
            a_d     = a_i;
            b_d     = b_i;
            idx_d   = LAST_IDX;
            fb_d    = FB_EQ;
            cnt_d   = '0;
          end
        end
        ST_COMPARE: begin
          fb_d  = fb_slice;
          cnt_d = cnt_q + 1'b1;
          if (idx_q != '0) begin
            idx_d = idx_q - 1'b1;
          end
          if ((idx_q == '0) || decided) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          if (ready_i) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      fb_q    <= FB_EQ;
      cnt_q   <= '0;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      fb_q    <= fb_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  // Outputs decode straight from state so reset takes effect without a clock.
  assign ready_o       = (state_q == ST_IDLE);
  assign busy_o        = (state_q == ST_COMPARE);
  assign valid_o       = (state_q == ST_DONE);
  assign less_o        = valid_o && (fb_q == FB_LT);
  assign greater_o     = valid_o && (fb_q == FB_GT);
  assign equal_o       = valid_o && (fb_q == FB_EQ);
  assign chunks_used_o = valid_o ? cnt_q : '0;

  fb_legal_a: assert property (@(posedge clk_i) disable iff (!rst_n_i) fb_q != 2'b11);

endmodule

// File: tb/tb_cmp_chunk_sequencer.sv
// Self-checking bench for cmp_chunk_sequencer across four parameterisations.
// Expected results come from an independent whole-operand model via a scoreboard queue.
module tb_cmp_chunk_sequencer;

  typedef struct { logic lt, eq, gt; int k; } exp_t;
  typedef struct { logic lt, eq, gt, rdy_ok; logic [2:0] cu; int lat; } obs_t;

  // Instance 0: 16/8 early-exit, 1: 16/8 full, 2: 32/8 early-exit, 3: 8/8 (single chunk)
  int unsigned W_OF  [4] = '{16, 16, 32, 8};
  int unsigned EE_OF [4] = '{1, 0, 1, 1};

  logic clk, rst_n;
  logic st [4];
  logic clr [4];
  logic rdy_in [4];
  logic rdy_o [4];
  logic vld [4];
  logic lt [4];
  logic eq [4];
  logic gt [4];
  logic bsy [4];
  logic [2:0] cu [4];
  logic [15:0] a0, b0, a1, b1;
  logic [31:0] a2, b2;
  logic [7:0]  a3, b3;
  logic [1:0] cu0, cu1;
  logic [2:0] cu2;
  logic [0:0] cu3;

  exp_t sbq [$];
  int n_cmp = 0;
  int n_bad = 0;

  always_comb begin
    cu[0] = {1'b0, cu0};
    cu[1] = {1'b0, cu1};
    cu[2] = cu2;
    cu[3] = {2'b00, cu3};
  end

  cmp_chunk_sequencer #(.WIDTH(16), .CHUNK(8), .EARLY_EXIT(1)) dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(st[0]), .ready_o(rdy_o[0]), .a_i(a0), .b_i(b0),
    .clear_i(clr[0]), .valid_o(vld[0]), .ready_i(rdy_in[0]), .less_o(lt[0]), .equal_o(eq[0]),
    .greater_o(gt[0]), .chunks_used_o(cu0), .busy_o(bsy[0]));

  cmp_chunk_sequencer #(.WIDTH(16), .CHUNK(8), .EARLY_EXIT(0)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(st[1]), .ready_o(rdy_o[1]), .a_i(a1), .b_i(b1),
    .clear_i(clr[1]), .valid_o(vld[1]), .ready_i(rdy_in[1]), .less_o(lt[1]), .equal_o(eq[1]),
    .greater_o(gt[1]), .chunks_used_o(cu1), .busy_o(bsy[1]));

  cmp_chunk_sequencer #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(1)) dut2 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(st[2]), .ready_o(rdy_o[2]), .a_i(a2), .b_i(b2),
    .clear_i(clr[2]), .valid_o(vld[2]), .ready_i(rdy_in[2]), .less_o(lt[2]), .equal_o(eq[2]),
    .greater_o(gt[2]), .chunks_used_o(cu2), .busy_o(bsy[2]));

  cmp_chunk_sequencer #(.WIDTH(8), .CHUNK(8), .EARLY_EXIT(1)) dut3 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(st[3]), .ready_o(rdy_o[3]), .a_i(a3), .b_i(b3),
    .clear_i(clr[3]), .valid_o(vld[3]), .ready_i(rdy_in[3]), .less_o(lt[3]), .equal_o(eq[3]),
    .greater_o(gt[3]), .chunks_used_o(cu3), .busy_o(bsy[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] wmask(input int unsigned w);
    logic [31:0] m;
    m = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return m;
  endfunction

  // Whole-operand compare for the result; first differing byte from the top gives k.
  function automatic exp_t model(input logic [31:0] a_in, input logic [31:0] b_in,
                                 input int unsigned w, input int unsigned ee);
    exp_t e;
    logic [31:0] a, b;
    int n;
    bit found;
    a = a_in & wmask(w);
    b = b_in & wmask(w);
    n = int'(w / 8);
    e.lt = (a < b);
    e.eq = (a == b);
    e.gt = (a > b);
    e.k = n;
    found = 1'b0;
    if (ee != 0) begin
      for (int i = n - 1; i >= 0; i--) begin
        if (!found && (a[i*8 +: 8] != b[i*8 +: 8])) begin
          e.k = n - i;
          found = 1'b1;
        end
      end
    end
    return e;
  endfunction

  task automatic set_ops(input int d, input logic [31:0] a, input logic [31:0] b);
    case (d)
      0: begin a0 = a[15:0]; b0 = b[15:0]; end
      1: begin a1 = a[15:0]; b1 = b[15:0]; end
      2: begin a2 = a;       b2 = b;       end
      default: begin a3 = a[7:0]; b3 = b[7:0]; end
    endcase
  endtask

  // Issues one request, counts edges from acceptance to valid, then consumes the result.
  task automatic transact(input int d, input logic [31:0] a, input logic [31:0] b,
                          output obs_t o);
    int n;
    sbq.push_back(model(a, b, W_OF[d], EE_OF[d]));
    n = 0;
    while (!rdy_o[d] && n < 50) begin @(posedge clk); #1; n++; end
    o.rdy_ok = rdy_o[d];
    set_ops(d, a, b);
    st[d] = 1'b1;
    @(posedge clk); #1;
    st[d] = 1'b0;
    o.lat = 0;
    while (!vld[d] && o.lat < 64) begin @(posedge clk); #1; o.lat++; end
    o.lt = lt[d]; o.eq = eq[d]; o.gt = gt[d]; o.cu = cu[d];
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int d = 0; d < 4; d++) begin
      st[d] = 1'b0; clr[d] = 1'b0; rdy_in[d] = 1'b1;
    end
    set_ops(0, 0, 0); set_ops(1, 0, 0); set_ops(2, 0, 0); set_ops(3, 0, 0);
    #12;
    for (int d = 0; d < 4; d++) begin
      n_cmp++; if (rdy_o[d] !== 1'b1) begin n_bad++; $display("FAIL reset ready_o[%0d]: got %b expected 1", d, rdy_o[d]); end
      n_cmp++; if (vld[d] !== 1'b0) begin n_bad++; $display("FAIL reset valid_o[%0d]: got %b expected 0", d, vld[d]); end
      n_cmp++; if (bsy[d] !== 1'b0) begin n_bad++; $display("FAIL reset busy_o[%0d]: got %b expected 0", d, bsy[d]); end
      n_cmp++; if ({lt[d], eq[d], gt[d]} !== 3'b000) begin n_bad++; $display("FAIL reset lt/eq/gt[%0d]: got %b%b%b expected 000", d, lt[d], eq[d], gt[d]); end
      n_cmp++; if (cu[d] !== 3'd0) begin n_bad++; $display("FAIL reset chunks_used[%0d]: got %0d expected 0", d, cu[d]); end
    end
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    int          td [14] = '{0, 0, 0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3};
    logic [31:0] ta [14] = '{32'h1234, 32'h1200, 32'hABCD, 32'hFFFF, 32'h0000, 32'h1200, 32'h1234,
                             32'h5500, 32'h00FF0000, 32'h11223344, 32'h80000000, 32'h05, 32'hFF, 32'h80};
    logic [31:0] tv [14] = '{32'h1235, 32'h34FF, 32'hABCD, 32'h0000, 32'h0000, 32'h34FF, 32'h1235,
                             32'h5501, 32'h00FEFFFF, 32'h11223345, 32'h7FFFFFFF, 32'h06, 32'hFF, 32'h7F};
    obs_t o;
    exp_t e;
    for (int i = 0; i < 14; i++) begin
      transact(td[i], ta[i], tv[i], o);
      e = sbq.pop_front();
      n_cmp++; if (o.rdy_ok !== 1'b1) begin n_bad++; $display("FAIL dir[%0d] ready before start: got %b expected 1", i, o.rdy_ok); end
      n_cmp++; if (o.lat != e.k) begin n_bad++; $display("FAIL dir[%0d] latency: got %0d expected %0d", i, o.lat, e.k); end
      n_cmp++; if ({o.lt, o.eq, o.gt} !== {e.lt, e.eq, e.gt}) begin n_bad++; $display("FAIL dir[%0d] lt/eq/gt: got %b%b%b expected %b%b%b", i, o.lt, o.eq, o.gt, e.lt, e.eq, e.gt); end
      n_cmp++; if (o.cu !== 3'(e.k)) begin n_bad++; $display("FAIL dir[%0d] chunks_used: got %0d expected %0d", i, o.cu, e.k); end
    end
  endtask

  task automatic test_hold_stable;
    exp_t e;
    int lat;
    sbq.push_back(model(32'hABCD, 32'hABCD, 16, 1));
    rdy_in[0] = 1'b0;
    set_ops(0, 32'hABCD, 32'hABCD);
    st[0] = 1'b1;
    @(posedge clk); #1;
    st[0] = 1'b0;
    set_ops(0, 32'h0000, 32'hFFFF);
    lat = 0;
    while (!vld[0] && lat < 64) begin @(posedge clk); #1; lat++; end
    e = sbq.pop_front();
    n_cmp++; if (lat != e.k) begin n_bad++; $display("FAIL hold latency: got %0d expected %0d", lat, e.k); end
    for (int c = 0; c < 5; c++) begin
      n_cmp++; if (vld[0] !== 1'b1) begin n_bad++; $display("FAIL hold[%0d] valid_o: got %b expected 1", c, vld[0]); end
      n_cmp++; if ({lt[0], eq[0], gt[0]} !== {e.lt, e.eq, e.gt}) begin n_bad++; $display("FAIL hold[%0d] lt/eq/gt: got %b%b%b expected %b%b%b", c, lt[0], eq[0], gt[0], e.lt, e.eq, e.gt); end
      n_cmp++; if (cu[0] !== 3'(e.k)) begin n_bad++; $display("FAIL hold[%0d] chunks_used: got %0d expected %0d", c, cu[0], e.k); end
      n_cmp++; if (rdy_o[0] !== 1'b0) begin n_bad++; $display("FAIL hold[%0d] ready_o: got %b expected 0", c, rdy_o[0]); end
      @(posedge clk); #1;
    end
    rdy_in[0] = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (vld[0] !== 1'b0) begin n_bad++; $display("FAIL hold release valid_o: got %b expected 0", vld[0]); end
    n_cmp++; if (rdy_o[0] !== 1'b1) begin n_bad++; $display("FAIL hold release ready_o: got %b expected 1", rdy_o[0]); end
  endtask

  task automatic test_start_ignored;
    exp_t e;
    int lat;
    sbq.push_back(model(32'h00FF0000, 32'h00FEFFFF, 32, 1));
    set_ops(2, 32'h00FF0000, 32'h00FEFFFF);
    st[2] = 1'b1;
    @(posedge clk); #1;
    set_ops(2, 32'h00000000, 32'h00000001);
    @(posedge clk); #1;
    st[2] = 1'b0;
    lat = 1;
    while (!vld[2] && lat < 64) begin @(posedge clk); #1; lat++; end
    e = sbq.pop_front();
    n_cmp++; if (lat != e.k) begin n_bad++; $display("FAIL restart latency: got %0d expected %0d", lat, e.k); end
    n_cmp++; if ({lt[2], eq[2], gt[2]} !== {e.lt, e.eq, e.gt}) begin n_bad++; $display("FAIL restart lt/eq/gt: got %b%b%b expected %b%b%b", lt[2], eq[2], gt[2], e.lt, e.eq, e.gt); end
    n_cmp++; if (cu[2] !== 3'(e.k)) begin n_bad++; $display("FAIL restart chunks_used: got %0d expected %0d", cu[2], e.k); end
    @(posedge clk); #1;
    n_cmp++; if ({rdy_o[2], bsy[2]} !== 2'b10) begin n_bad++; $display("FAIL restart post-consume ready/busy: got %b%b expected 10", rdy_o[2], bsy[2]); end
  endtask

  task automatic test_clear;
    obs_t o;
    exp_t e;
    set_ops(2, 32'h11223344, 32'h11223345);
    st[2] = 1'b1;
    @(posedge clk); #1;
    st[2] = 1'b0;
    @(posedge clk); #1;
    clr[2] = 1'b1;
    @(posedge clk); #1;
    clr[2] = 1'b0;
    n_cmp++; if ({rdy_o[2], bsy[2], vld[2]} !== 3'b100) begin n_bad++; $display("FAIL clear ready/busy/valid: got %b%b%b expected 100", rdy_o[2], bsy[2], vld[2]); end
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      n_cmp++; if (vld[2] !== 1'b0) begin n_bad++; $display("FAIL clear[%0d] valid_o: got %b expected 0", c, vld[2]); end
    end
    clr[2] = 1'b1; st[2] = 1'b1;
    @(posedge clk); #1;
    clr[2] = 1'b0; st[2] = 1'b0;
    n_cmp++; if ({rdy_o[2], bsy[2]} !== 2'b10) begin n_bad++; $display("FAIL clear+start ready/busy: got %b%b expected 10", rdy_o[2], bsy[2]); end
    transact(2, 32'hDEAD0001, 32'hDEAD0000, o);
    e = sbq.pop_front();
    n_cmp++; if (o.lat != e.k) begin n_bad++; $display("FAIL post-clear latency: got %0d expected %0d", o.lat, e.k); end
    n_cmp++; if ({o.lt, o.eq, o.gt, o.cu} !== {e.lt, e.eq, e.gt, 3'(e.k)}) begin n_bad++; $display("FAIL post-clear result: got %b%b%b/%0d expected %b%b%b/%0d", o.lt, o.eq, o.gt, o.cu, e.lt, e.eq, e.gt, e.k); end
  endtask

  task automatic test_async_reset;
    obs_t o;
    exp_t e;
    int n;
    set_ops(0, 32'hABCD, 32'hABCD);
    rdy_in[0] = 1'b0;
    st[0] = 1'b1;
    @(posedge clk); #1;
    st[0] = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    n_cmp++; if ({rdy_o[0], bsy[0], vld[0]} !== 3'b100) begin n_bad++; $display("FAIL areset compare ready/busy/valid: got %b%b%b expected 100", rdy_o[0], bsy[0], vld[0]); end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    st[0] = 1'b1;
    @(posedge clk); #1;
    st[0] = 1'b0;
    n = 0;
    while (!vld[0] && n < 64) begin @(posedge clk); #1; n++; end
    n_cmp++; if (vld[0] !== 1'b1) begin n_bad++; $display("FAIL areset reaching done valid_o: got %b expected 1", vld[0]); end
    #3 rst_n = 1'b0;
    #1;
    n_cmp++; if ({vld[0], lt[0], eq[0], gt[0], cu[0]} !== 7'b0000000) begin n_bad++; $display("FAIL areset done outputs: got v%b r%b%b%b cu%0d expected all 0", vld[0], lt[0], eq[0], gt[0], cu[0]); end
    n_cmp++; if (rdy_o[0] !== 1'b1) begin n_bad++; $display("FAIL areset done ready_o: got %b expected 1", rdy_o[0]); end
    #2 rst_n = 1'b1;
    rdy_in[0] = 1'b1;
    @(posedge clk); #1;
    transact(0, 32'h4321, 32'h4300, o);
    e = sbq.pop_front();
    n_cmp++; if (o.lat != e.k) begin n_bad++; $display("FAIL post-reset latency: got %0d expected %0d", o.lat, e.k); end
    n_cmp++; if ({o.lt, o.eq, o.gt, o.cu} !== {e.lt, e.eq, e.gt, 3'(e.k)}) begin n_bad++; $display("FAIL post-reset result: got %b%b%b/%0d expected %b%b%b/%0d", o.lt, o.eq, o.gt, o.cu, e.lt, e.eq, e.gt, e.k); end
  endtask

  task automatic test_back_to_back;
    obs_t o;
    exp_t e;
    logic [31:0] a, b;
    for (int d = 0; d < 4; d++) begin
      for (int i = 0; i < 8; i++) begin
        a = $urandom & wmask(W_OF[d]);
        case ($urandom_range(0, 3))
          0: b = a;
          1: b = a ^ (32'd1 << $urandom_range(0, W_OF[d] - 1));
          2: b = $urandom;
          default: b = a + 32'd1;
        endcase
        b = b & wmask(W_OF[d]);
        transact(d, a, b, o);
        e = sbq.pop_front();
        n_cmp++; if (o.lat != e.k) begin n_bad++; $display("FAIL b2b[%0d.%0d] latency a=%h b=%h: got %0d expected %0d", d, i, a, b, o.lat, e.k); end
        n_cmp++; if ({o.lt, o.eq, o.gt} !== {e.lt, e.eq, e.gt}) begin n_bad++; $display("FAIL b2b[%0d.%0d] lt/eq/gt a=%h b=%h: got %b%b%b expected %b%b%b", d, i, a, b, o.lt, o.eq, o.gt, e.lt, e.eq, e.gt); end
        n_cmp++; if (o.cu !== 3'(e.k)) begin n_bad++; $display("FAIL b2b[%0d.%0d] chunks_used: got %0d expected %0d", d, i, o.cu, e.k); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold_stable();
    test_start_ignored();
    test_clear();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cmp_chunk_sequencer.md
Name: cmp_chunk_sequencer

Overview:
- Multi-cycle magnitude comparator for the square-root datapath.
- Compares two WIDTH-bit unsigned operands by iterating one CHUNK-bit slice per cycle, MSB chunk first.
- Carries a 2-bit decided/undecided feedback code between slices.
- Valid/ready handshake on both sides; sits between the sqrt iteration control and the remainder-vs-trial-value compare.

Parameters:
- WIDTH, 16, operand width; must be an integer multiple of CHUNK.
- CHUNK, 8, bits compared per cycle.
- EARLY_EXIT, 1, 1 = stop as soon as a chunk decides the result; 0 = always process all NCHUNK = WIDTH/CHUNK chunks.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- start_i  in  1  request valid; operands on a_i/b_i.
- ready_o  out  1  block idle, request can be accepted.
- a_i  in  WIDTH  operand A, unsigned.
- b_i  in  WIDTH  operand B, unsigned.
- clear_i  in  1  synchronous abort; returns to IDLE.
- valid_o  out  1  result valid.
- ready_i  in  1  consumer accepts result.
- less_o  out  1  A < B.
- equal_o  out  1  A == B.
- greater_o  out  1  A > B.
- chunks_used_o  out  clog2(NCHUNK+1)  number of chunks evaluated for this result.
- busy_o  out  1  in COMPARE state.

Behaviour:
- Feedback code fb (registered, 2 bits):
  - 00 = equal so far.
  - 10 = A<B decided.
  - 01 = A>B decided.
  - 11 is never generated; an assertion checks for it.
- Slice rule:
  - fb=10 or fb=01 passes through unchanged.
  - fb=00 yields 10 if chunkA<chunkB, 01 if chunkA>chunkB, else 00.
- States:
  - IDLE: ready_o=1.
  - COMPARE: busy_o=1.
  - DONE: valid_o=1.
- IDLE -> COMPARE on start_i && ready_o:
  - latch a_i/b_i; later input changes are ignored;
  - set idx=NCHUNK-1, fb=00, cnt=0.
- COMPARE, each cycle:
  - evaluate chunk idx, i.e. bits [idx*CHUNK +: CHUNK], with fb;
  - register the new fb; cnt++; idx--.
  - Go to DONE when idx==0, or when EARLY_EXIT=1 and the new fb != 00. Otherwise stay.
- DONE:
  - less_o = (fb==10), greater_o = (fb==01), equal_o = (fb==00).
  - chunks_used_o = cnt.
  - All outputs held stable while ready_i=0.
  - valid_o && ready_i -> IDLE; ready_o high the following cycle. No same-cycle restart.
- Latency: valid_o rises k clock edges after the accepting edge, where k = chunks evaluated.
  - k = NCHUNK when EARLY_EXIT=0.
  - 1 <= k <= NCHUNK when EARLY_EXIT=1.
- start_i while not ready_o: ignored; requester holds start_i.
- clear_i: highest priority; from any state -> IDLE next edge, with fb/cnt cleared and valid_o low. A pending result is discarded. clear_i && start_i in IDLE: clear wins, request not accepted.
- Reset (rst_n_i low, any time, including mid-COMPARE or DONE):
  - immediately state=IDLE, fb=00, cnt=0, idx=0, latched operands 0;
  - valid_o=0, less_o=0, equal_o=0, greater_o=0, busy_o=0, chunks_used_o=0;
  - ready_o=1 (decoded from IDLE).
- Result outputs are 0 outside DONE.
- NCHUNK=1 degenerates to single-cycle COMPARE, k=1.

Decomposition:
- Shared package cmp_seq_pkg:
  - FB_EQ=2'b00, FB_LT=2'b10, FB_GT=2'b01;
  - state encoding IDLE/COMPARE/DONE;
  - function for NCHUNK and the counter width.
- One sub-module cmp_chunk_slice (combinational): ports chunk A, chunk B, fb in, fb out, parameter CHUNK. Implements the slice rule. The sequencer instantiates exactly one and time-multiplexes it.
- Elaboration check: WIDTH % CHUNK == 0, else error.

Test Plan:
- A=0x1234, B=0x1235, EARLY_EXIT=1 -> valid_o 2 edges after accept; less_o=1, equal_o=0, greater_o=0, chunks_used_o=2.
- A=0x1200, B=0x34FF, EARLY_EXIT=1 -> valid_o after 1 edge, less_o=1, chunks_used_o=1. Same operands with EARLY_EXIT=0 -> 2 edges, less_o=1.
- A=B=0xABCD -> equal_o=1, less_o=0, greater_o=0, chunks_used_o=2. Then hold ready_i=0 for 5 cycles -> valid_o and results stable; ready_o=0 throughout. Change a_i/b_i during COMPARE -> result unaffected.
- WIDTH=32, CHUNK=8, A=0x00FF0000, B=0x00FEFFFF -> greater_o=1, chunks_used_o=2; a further start_i pulse during COMPARE is ignored.
- Pulse clear_i in the 2nd COMPARE cycle of a 32-bit compare -> IDLE next edge, valid_o never asserted, ready_o=1. A new request then completes normally.
- Drop rst_n_i asynchronously mid-COMPARE and again in DONE -> all outputs take reset values immediately without a clock edge; after release, ready_o=1 and the next compare is correct.
